punc_datapath_param: RTL

//  Parametrised next-generation PUnC LC3 datapath: PC, IR, MDR, address register, N-entry

---
 rtl/punc_datapath_param.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/punc_datapath_param.sv
`default_nettype none
// ============================================================================
// Module   : punc_datapath_param
// Brief    : Parametrised PUnC LC3 datapath (PC, IR, MDR, address register,
//            N-entry register file, 4-op ALU, sign-extenders, NZP codes) with
//            a request/ack sequencer for an external variable-latency memory.
// Config   : PUNC_MEM_WAIT_EN - when defined, an access holds until mem_ack;
//            otherwise every access completes one cycle after it starts.
// Notes    : ADDR_W must not exceed DATA_W (addresses are low bits of words).
// Revision : 1.0 - initial release
// ============================================================================
module punc_datapath_param #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int          NUM_REGS = 8,
  parameter int unsigned RESET_PC = 0,
  localparam int         RA_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        pc_op,
  input  logic              ir_ld,
  input  logic              addr_ld,
  input  logic [1:0]        mem_addr_sel,
  input  logic              mem_rd_req,
  input  logic              mem_wr_req,
  input  logic [RA_W-1:0]   rf_rd0_addr,
  input  logic [RA_W-1:0]   rf_rd1_addr,
  input  logic [RA_W-1:0]   rf_wr_addr,
  input  logic              rf_we,
  input  logic [1:0]        rf_wd_sel,
  input  logic              alu_a_sel,
  input  logic              alu_b_sel,
  input  logic [1:0]        imm_sel,
  input  logic [1:0]        alu_op,
  input  logic              nzp_ld,
  input  logic              nzp_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_busy,
  output logic              mdr_valid,
  output logic              req_drop,
  output logic [DATA_W-1:0] ir,
  output logic [2:0]        nzp,
  output logic              br_taken
);

  localparam logic [DATA_W-1:0] C_RESET_PC = DATA_W'(RESET_PC);
  localparam logic [DATA_W-1:0] C_ONE      = DATA_W'(1);

  typedef enum logic [0:0] {
    SEQ_IDLE   = 1'b0,
    SEQ_ACCESS = 1'b1
  } seq_state_e;

  // Architected state
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        nzp_q;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  // Sequencer state and latched request
  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic              lat_wr_q, lat_wr_d;
  logic              mdr_valid_q, mdr_valid_d;
  logic              req_drop_q, req_drop_d;
  logic              mdr_ld;

  // Combinational datapath
  logic [DATA_W-1:0] w_rf_rd0;
  logic [DATA_W-1:0] w_rf_rd1;
  logic [DATA_W-1:0] w_rf_wd;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu_a;
  logic [DATA_W-1:0] w_alu_b;
  logic [DATA_W-1:0] w_alu_out;
  logic [DATA_W-1:0] w_nzp_src;
  logic [2:0]        w_nzp_new;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_access_done;
  logic              w_busy;

`ifdef PUNC_MEM_WAIT_EN
  assign w_access_done = mem_ack;
`else
  // Fixed one-cycle access: the acknowledge has no meaning here.
  logic w_unused_ack;
  assign w_unused_ack  = mem_ack;
  assign w_access_done = 1'b1;
`endif

  assign w_rf_rd0 = rf_q[rf_rd0_addr];
  assign w_rf_rd1 = rf_q[rf_rd1_addr];
  assign w_alu_a  = alu_a_sel ? w_rf_rd0 : pc_q;
  assign w_alu_b  = alu_b_sel ? w_imm : w_rf_rd1;

  // Sign-extend the selected IR immediate field from its own MSB
  always_comb begin
    w_imm = '0;
    unique case (imm_sel)
      2'b00: w_imm = {{(DATA_W-5){ir_q[4]}},   ir_q[4:0]};
      2'b01: w_imm = {{(DATA_W-6){ir_q[5]}},   ir_q[5:0]};
      2'b10: w_imm = {{(DATA_W-9){ir_q[8]}},   ir_q[8:0]};
      2'b11: w_imm = {{(DATA_W-11){ir_q[10]}}, ir_q[10:0]};
    endcase
  end

  // Four-function ALU; ADD wraps naturally at DATA_W bits
  always_comb begin
    w_alu_out = '0;
    unique case (alu_op)
      2'b00: w_alu_out = w_alu_a + w_alu_b;
      2'b01: w_alu_out = w_alu_a & w_alu_b;
      2'b10: w_alu_out = w_alu_a;
      2'b11: w_alu_out = ~w_alu_a;
    endcase
  end

  // Register-file write data select
  always_comb begin
    w_rf_wd = w_alu_out;
    unique case (rf_wd_sel)
      2'b00:   w_rf_wd = pc_q;
      2'b01:   w_rf_wd = mdr_q;
      default: w_rf_wd = w_alu_out;
    endcase
  end

  // Memory address source while the sequencer is idle
  always_comb begin
    w_sel_addr = addr_q;
    unique case (mem_addr_sel)
      2'b00:   w_sel_addr = pc_q[ADDR_W-1:0];
      2'b01:   w_sel_addr = w_alu_out[ADDR_W-1:0];
      default: w_sel_addr = addr_q;
    endcase
  end

  // Condition codes: exactly one of N/Z/P from the signed source value
  assign w_nzp_src = nzp_sel ? mdr_q : w_alu_out;
  assign w_nzp_new = w_nzp_src[DATA_W-1] ? 3'b100 :
                     (w_nzp_src == '0)   ? 3'b010 : 3'b001;

  // PC next-state
  always_comb begin
    pc_d = pc_q;
    unique case (pc_op)
      2'b00: pc_d = pc_q;
      2'b01: pc_d = pc_q + C_ONE;
      2'b10: pc_d = w_alu_out;
      2'b11: pc_d = C_RESET_PC;
    endcase
  end

  // Sequencer next-state: accept in IDLE, complete in ACCESS, flag collisions
  always_comb begin
    state_d     = state_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_wr_d    = lat_wr_q;
    mdr_ld      = 1'b0;
    mdr_valid_d = 1'b0;
    req_drop_d  = req_drop_q;
    unique case (state_q)
      SEQ_IDLE: begin
        if (mem_rd_req || mem_wr_req) begin
          state_d     = SEQ_ACCESS;
          lat_addr_d  = w_sel_addr;
          lat_wdata_d = w_rf_rd1;
          lat_wr_d    = mem_wr_req;   // write wins a simultaneous request
          if (mem_rd_req && mem_wr_req) begin
            req_drop_d = 1'b1;
          end
        end
      end
      SEQ_ACCESS: begin
        if (mem_rd_req || mem_wr_req) begin
          req_drop_d = 1'b1;
        end
        if (w_access_done) begin
          state_d = SEQ_IDLE;
          if (!lat_wr_q) begin
            mdr_ld      = 1'b1;
            mdr_valid_d = 1'b1;
          end
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  // Architected registers and sequencer state; reset overrides every input
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= C_RESET_PC;
      ir_q        <= '0;
      mdr_q       <= '0;
      addr_q      <= '0;
      nzp_q       <= 3'b010;
      state_q     <= SEQ_IDLE;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_wr_q    <= 1'b0;
      mdr_valid_q <= 1'b0;
      req_drop_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      if (ir_ld)   ir_q   <= mdr_q;
      if (addr_ld) addr_q <= w_alu_out[ADDR_W-1:0];
      if (nzp_ld)  nzp_q  <= w_nzp_new;
      if (mdr_ld)  mdr_q  <= mem_rdata;
      state_q     <= state_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_wr_q    <= lat_wr_d;
      mdr_valid_q <= mdr_valid_d;
      req_drop_q  <= req_drop_d;
    end
  end

  // Register file: synchronous write, reads see the old value until the edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_we) begin
      rf_q[rf_wr_addr] <= w_rf_wd;
    end
  end

  assign w_busy    = (state_q == SEQ_ACCESS);
  assign mem_busy  = w_busy;
  assign mem_re    = w_busy && !lat_wr_q;
  assign mem_we    = w_busy &&  lat_wr_q;
  assign mem_addr  = w_busy ? lat_addr_q  : w_sel_addr;
  assign mem_wdata = w_busy ? lat_wdata_q : w_rf_rd1;
  assign mdr_valid = mdr_valid_q;
  assign req_drop  = req_drop_q;
  assign ir        = ir_q;
  assign nzp       = nzp_q;
  assign br_taken  = |(ir_q[11:9] & nzp_q);

endmodule
`default_nettype wire
